// File: rtl/cfg_frame_pkg.sv
// Shared types and constants for the configuration frame writer.
// ST_CRC exists only when CFG_FRAME_CRC_EN is defined.
package cfg_frame_pkg;

    localparam logic [7:0]  OP_WRITE          = 8'h01;
    localparam logic [7:0]  OP_END            = 8'h02;
    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;
    localparam logic [31:0] CRC_POLY          = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT          = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
`ifdef CFG_FRAME_CRC_EN
        ,
        ST_CRC
`endif
    } state_t;

endpackage

// File: rtl/cfg_crc32_step.sv
// Combinational CRC-32 update over one word, MSB first, no reflection, no final xor.
// Used by config_frame_writer only when CFG_FRAME_CRC_EN is defined.
module cfg_crc32_step
    import cfg_frame_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [31:0]  crc_in,
    input  logic [W-1:0] data,
    output logic [31:0]  crc_out
);

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/config_frame_writer.sv
// Streams sync/command/data words into a column's frame-latch bank with fixed setup/strobe/hold timing.
// Optional CFG_FRAME_CRC_EN adds a CRC-32 check word after END.
//
// state     | meaning
// ST_IDLE   | unarmed, discarding words until SYNC_WORD
// ST_CMD    | waiting for WRITE or END command
// ST_DATA   | waiting for the frame data word
// ST_SETUP  | FrameData stable, strobe low
// ST_STROBE | one-hot strobe on latched frame index
// ST_HOLD   | FrameData held, strobe low
// ST_CRC    | (CRC build only) waiting for expected CRC word
module config_frame_writer
    import cfg_frame_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                NUM_FRAMES   = 20,
    parameter int                FRAME_ADDR_W = 5,
    parameter logic [DATA_W-1:0] SYNC_WORD    = DEFAULT_SYNC_WORD
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_W-1:0]     FrameData,
    output logic [NUM_FRAMES-1:0] FrameStrobe,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    state_t                    state, state_next;
    logic [FRAME_ADDR_W-1:0]   frame_idx;
    logic                      accept;
    logic [7:0]                opcode;
    logic [FRAME_ADDR_W-1:0]   cmd_idx;
    logic                      idx_ok;
    logic                      load_idx, load_data, set_error, clr_error, done_next;
    logic                      ready_next;
    logic [NUM_FRAMES-1:0]     strobe_next;

`ifdef CFG_FRAME_CRC_EN
    logic [31:0] crc_q, crc_next;
    logic        crc_clear, crc_update;

    cfg_crc32_step #(.W(DATA_W)) u_crc (
        .crc_in  (crc_q),
        .data    (s_data),
        .crc_out (crc_next)
    );
`endif

    assign accept  = s_valid && s_ready;
    assign opcode  = s_data[DATA_W-1 -: 8];
    assign cmd_idx = s_data[FRAME_ADDR_W-1:0];
    assign idx_ok  = 32'(cmd_idx) < NUM_FRAMES;
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        load_idx   = 1'b0;
        load_data  = 1'b0;
        set_error  = 1'b0;
        clr_error  = 1'b0;
        done_next  = 1'b0;
`ifdef CFG_FRAME_CRC_EN
        crc_clear  = 1'b0;
        crc_update = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept && s_data == SYNC_WORD) begin
                    state_next = ST_CMD;
                    clr_error  = 1'b1;
`ifdef CFG_FRAME_CRC_EN
                    crc_clear  = 1'b1;
`endif
                end
            end
            ST_CMD: begin
                if (accept) begin
                    if (opcode == OP_WRITE && idx_ok) begin
                        load_idx   = 1'b1;
                        state_next = ST_DATA;
                    end else if (opcode == OP_END) begin
`ifdef CFG_FRAME_CRC_EN
                        state_next = ST_CRC;
`else
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
`endif
                    end else begin
                        // covers bad index, unknown opcodes and a repeated SYNC_WORD
                        set_error  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    load_data  = 1'b1;
`ifdef CFG_FRAME_CRC_EN
                    crc_update = 1'b1;
`endif
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP:  state_next = ST_STROBE;
            ST_STROBE: state_next = ST_HOLD;
            ST_HOLD:   state_next = ST_CMD;
`ifdef CFG_FRAME_CRC_EN
            ST_CRC: begin
                if (accept) begin
                    if (s_data[31:0] == crc_q) begin
                        done_next = 1'b1;
                    end else begin
                        set_error = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // s_ready and FrameStrobe are registered from the next state so they line up with it
    assign ready_next  = !(state_next inside {ST_SETUP, ST_STROBE, ST_HOLD});
    assign strobe_next = (state_next == ST_STROBE) ? (NUM_FRAMES'(1) << frame_idx) : '0;

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            frame_idx   <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            s_ready     <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_next;
            FrameStrobe <= strobe_next;
            s_ready     <= ready_next;
            done        <= done_next;
            if (load_idx) begin
                frame_idx <= cmd_idx;
            end
            if (load_data) begin
                FrameData <= s_data;
            end
            if (set_error) begin
                error <= 1'b1;
            end else if (clr_error) begin
                error <= 1'b0;
            end
        end
    end

`ifdef CFG_FRAME_CRC_EN
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            crc_q <= CRC_INIT;
        end else if (crc_clear) begin
            crc_q <= CRC_INIT;
        end else if (crc_update) begin
            crc_q <= crc_next;
        end
    end
`endif

endmodule

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Sequences configuration loading into a fabric column's frame-latch bank. The bank drives the per-tile config bits that the primitive wrappers export to fabric top.
- Accepts a word stream over a valid/ready interface, validates a sync word and frame commands, and drives FrameData with one-hot FrameStrobe pulses.
- Timing is fixed: FrameData is stable one cycle before the strobe, for one cycle of strobe, and one cycle after.
- Sits between the bitstream source (UART/USB deserialiser) and the column's frame latches.

Parameters:
- DATA_W, 32, width of stream words and FrameData.
- NUM_FRAMES, 20, number of frame strobes (frames per column).
- FRAME_ADDR_W, 5, width of frame index field; must satisfy 2**FRAME_ADDR_W >= NUM_FRAMES.
- SYNC_WORD, 32'hFAB0_FAB1, word that arms the writer.

Ports:
- CLK  input  1  single clock.
- resetn  input  1  synchronous active-low reset.
- s_data  input  DATA_W  stream word.
- s_valid  input  1  s_data valid.
- s_ready  output  1  writer accepts word this cycle.
- FrameData  output  DATA_W  frame data to latch bank.
- FrameStrobe  output  NUM_FRAMES  one-hot latch enable.
- busy  output  1  writer armed (any state except IDLE).
- done  output  1  one-cycle pulse on accepted END command.
- error  output  1  sticky fault flag.

Behaviour:
- Reset (resetn low at posedge): state IDLE; FrameData=0; FrameStrobe=0; s_ready=1; busy=0; done=0; error=0.
- Reset mid-frame aborts immediately. A strobe in flight is dropped on the same edge.
- Transfer rule: a word is accepted when s_valid && s_ready at posedge. s_ready is a registered function of state: 1 in IDLE/CMD/DATA, 0 in SETUP/STROBE/HOLD.
- States and transitions:
  - IDLE: accepted word == SYNC_WORD -> CMD and clear error. Any other accepted word is discarded and the writer stays in IDLE.
  - CMD: command word layout is [31:24] opcode, [FRAME_ADDR_W-1:0] frame index, all other bits ignored.
    - opcode 8'h01 with index < NUM_FRAMES -> latch index, go to DATA.
    - opcode 8'h01 with index >= NUM_FRAMES -> error=1, go to IDLE.
    - opcode 8'h02 (END) -> done pulse next cycle, go to IDLE.
    - any other opcode -> error=1, go to IDLE.
    - SYNC_WORD received in CMD is treated as an unknown opcode.
  - DATA: accepted word -> FrameData <= word, go to SETUP.
  - SETUP (1 cycle): FrameStrobe=0, FrameData held.
  - STROBE (1 cycle): FrameStrobe[index]=1, all other bits 0.
  - HOLD (1 cycle): FrameStrobe=0, FrameData held; then go to CMD.
- Latency: DATA word accepted at edge N -> FrameData valid from N+1, strobe high during cycle N+2, s_ready high again from N+4.
- Minimum frame period is 5 cycles (CMD, DATA, SETUP, STROBE, HOLD).
- FrameData holds its last value in IDLE/CMD/DATA. FrameStrobe is never multi-hot.
- done and error are registered. error holds until the next accepted SYNC_WORD or reset.
- s_valid low in any accepting state: wait indefinitely, no timeout.

Optional Feature:
- Macro: CFG_FRAME_CRC_EN.
- With the macro:
  - A CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no reflection) runs over every DATA word.
  - After END, the writer enters CRC state and accepts one more word holding the expected CRC.
  - Match -> done pulse. Mismatch -> error=1 with no done. Either way, go to IDLE.
  - The CRC is reinitialised on SYNC_WORD.
- Without the macro: the CRC state and logic are absent, and END is handled as above.

Decomposition:
- Package cfg_frame_pkg: state enum, opcode constants (OP_WRITE=8'h01, OP_END=8'h02), default SYNC_WORD, CRC polynomial/init.
- Sub-module cfg_crc32_step: combinational one-word CRC update, instantiated only under CFG_FRAME_CRC_EN.

Test Plan:
- Reset then stream SYNC, 0x01000003, 0xDEADBEEF, 0x02000000 -> FrameData=0xDEADBEEF one cycle before FrameStrobe=20'h00008 (one cycle wide), then done pulse, busy=0.
- Words 0x12345678, 0x01000001 before SYNC -> ignored: no strobe, error=0, s_ready stays 1.
- After SYNC, send 0x01000014 (index 20) -> error=1, IDLE, no strobe. Next SYNC clears error.
- Back-to-back frames 0..19 with s_valid always high -> 20 strobes in index order, each 5 cycles apart, s_ready low exactly in SETUP/STROBE/HOLD.
- Assert resetn=0 during the STROBE cycle -> next cycle FrameStrobe=0, FrameData=0, state IDLE.
- With CFG_FRAME_CRC_EN: frame 0 data 0x00000000, END, correct CRC -> done pulse; repeat with CRC^1 -> error=1, no done.
